// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle events on i_Event into visible LED blinks, each
// followed by a forced dark gap; events arriving mid-blink are queued.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | LED dark, nothing pending, timer held at 0
// ON    | LED lit, timer counts 0..ON_TIME-1
// GAP   | LED forced dark, timer counts 0..OFF_TIME-1, then ON or IDLE
module led_pulse_stretcher #(
  parameter int COUNTER_WIDTH = 16,
  parameter int ON_TIME       = 50000,
  parameter int OFF_TIME      = 50000,
  parameter int PENDING_WIDTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_Event,
  output logic o_LED,
  output logic o_Busy,
  output logic o_Overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] ON_LAST  = COUNTER_WIDTH'(ON_TIME - 1);
  localparam logic [COUNTER_WIDTH-1:0] OFF_LAST = COUNTER_WIDTH'(OFF_TIME - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = {PENDING_WIDTH{1'b1}};

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] timer, timer_nxt;
  logic [PENDING_WIDTH-1:0] pending, pending_nxt;
  logic                     prev;
  logic                     event_edge;
  logic                     go_on;
  logic                     ovf_nxt;

  assign event_edge = i_Event && !prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      pending    <= '0;
      prev       <= 1'b0;
      o_LED      <= 1'b0;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pending    <= pending_nxt;
      prev       <= i_Event;
      o_LED      <= (state_nxt == ST_ON);
      o_Busy     <= (state_nxt != ST_IDLE) || (pending_nxt != '0);
      o_Overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 1'b1;
    pending_nxt = pending;
    ovf_nxt     = 1'b0;
    go_on       = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (event_edge || (pending != '0)) begin
          state_nxt = ST_ON;
          go_on     = 1'b1;
        end
      end
      ST_ON: begin
        if (timer == ON_LAST) begin
          state_nxt = ST_GAP;
          timer_nxt = '0;
        end
      end
      ST_GAP: begin
        if (timer == OFF_LAST) begin
          timer_nxt = '0;
          if (event_edge || (pending != '0)) begin
            state_nxt = ST_ON;
            go_on     = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    // A fresh edge is always preferred over the queue when starting a blink,
    // so entering ON without an edge implies pending is non-zero.
    if (go_on) begin
      if (!event_edge) pending_nxt = pending - 1'b1;
    end else if (event_edge) begin
      if (pending != PEND_MAX) pending_nxt = pending + 1'b1;
      else                     ovf_nxt     = 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON_TIME=4, OFF_TIME=3,
// PENDING_WIDTH=2; expected values are worked out by hand per scenario.
module tb_led_pulse_stretcher;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_Event = 1'b0;
  logic o_LED, o_Busy, o_Overflow;

  int vec = 0;
  int err = 0;

  // per-scenario observation stats, maintained by step()
  int   rises, falls, bad_on, bad_gap, ovf_cnt, busy_low;
  int   on_len, dark_len;
  logic seen_fall;
  logic led_d;

  led_pulse_stretcher #(
    .COUNTER_WIDTH(8),
    .ON_TIME(4),
    .OFF_TIME(3),
    .PENDING_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_Event(i_Event),
    .o_LED(o_LED),
    .o_Busy(o_Busy),
    .o_Overflow(o_Overflow)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    rises = 0; falls = 0; bad_on = 0; bad_gap = 0; ovf_cnt = 0; busy_low = 0;
    on_len = 0; dark_len = 0; seen_fall = 1'b0; led_d = o_LED;
  endtask

  // Drive i_Event for the next rising edge, then observe 1 time unit later.
  task automatic step(input logic ev);
    i_Event = ev;
    @(posedge clk);
    #1;
    if (o_Overflow) ovf_cnt++;
    if (!o_Busy) busy_low++;
    if (o_LED && !led_d) begin
      rises++;
      if (seen_fall && dark_len != 3) bad_gap++;
      on_len = 0;
    end
    if (!o_LED && led_d) begin
      falls++;
      if (on_len != 4) bad_on++;
      seen_fall = 1'b1;
      dark_len  = 0;
    end
    if (o_LED) on_len++;
    else       dark_len++;
    led_d = o_LED;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (o_LED !== 1'b0) begin err++; $display("FAIL reset_led got %b want 0", o_LED); end
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", o_Busy); end
    vec++; if (o_Overflow !== 1'b0) begin err++; $display("FAIL reset_ovf got %b want 0", o_Overflow); end
    // i_Event already high at release must count as one event
    i_Event = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_stats();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      if (i == 1) begin
        vec++; if (o_LED !== 1'b1) begin err++; $display("FAIL release_high_led got %b want 1", o_LED); end
      end
      if (i == 8) begin
        vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL release_high_busy got %b want 0", o_Busy); end
      end
    end
    vec++; if (rises !== 1) begin err++; $display("FAIL release_high_blinks got %0d want 1", rises); end
    for (int i = 0; i < 3; i++) step(1'b0);
  endtask

  task automatic test_single();
    logic exp_led [8];
    logic exp_busy[8];
    exp_led  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      step(i == 0);
      vec++; if (o_LED !== exp_led[i]) begin err++; $display("FAIL single_led[%0d] got %b want %b", i, o_LED, exp_led[i]); end
      vec++; if (o_Busy !== exp_busy[i]) begin err++; $display("FAIL single_busy[%0d] got %b want %b", i, o_Busy, exp_busy[i]); end
    end
  endtask

  task automatic test_held();
    clear_stats();
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    vec++; if (rises !== 1) begin err++; $display("FAIL held_blinks got %0d want 1", rises); end
    vec++; if (bad_on !== 0) begin err++; $display("FAIL held_on_len bad=%0d want 0", bad_on); end
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL held_busy_end got %b want 0", o_Busy); end
  endtask

  task automatic test_queueing();
    clear_stats();
    // edges at k, k+2, k+4, k+6 -> four blinks back to back
    for (int i = 1; i <= 28; i++) step((i <= 8) && (i % 2 == 1));
    vec++; if (busy_low !== 0) begin err++; $display("FAIL queue_busy_held low_cycles=%0d want 0", busy_low); end
    step(1'b0);
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL queue_busy_end got %b want 0", o_Busy); end
    vec++; if (rises !== 4) begin err++; $display("FAIL queue_blinks got %0d want 4", rises); end
    vec++; if (bad_on !== 0) begin err++; $display("FAIL queue_on_len bad=%0d want 0", bad_on); end
    vec++; if (bad_gap !== 0) begin err++; $display("FAIL queue_gap_len bad=%0d want 0", bad_gap); end
    vec++; if (ovf_cnt !== 0) begin err++; $display("FAIL queue_overflow got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_overflow();
    clear_stats();
    // edges at k..k+10 step 2; the k+7 gap end drains one, k+10 finds queue full
    for (int i = 1; i <= 35; i++) begin
      step((i <= 12) && (i % 2 == 1));
      if (i == 11) begin
        vec++; if (o_Overflow !== 1'b1) begin err++; $display("FAIL ovf_pulse got %b want 1", o_Overflow); end
      end
      if (i == 12) begin
        vec++; if (o_Overflow !== 1'b0) begin err++; $display("FAIL ovf_one_cycle got %b want 0", o_Overflow); end
      end
    end
    vec++; if (busy_low !== 0) begin err++; $display("FAIL ovf_busy_held low_cycles=%0d want 0", busy_low); end
    step(1'b0);
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL ovf_busy_end got %b want 0", o_Busy); end
    vec++; if (rises !== 5) begin err++; $display("FAIL ovf_blinks got %0d want 5", rises); end
    vec++; if (ovf_cnt !== 1) begin err++; $display("FAIL ovf_count got %0d want 1", ovf_cnt); end
  endtask

  task automatic test_gap_edge();
    clear_stats();
    for (int i = 1; i <= 15; i++) begin
      step((i == 1) || (i == 8));
      if (i == 7) begin
        vec++; if (o_LED !== 1'b0) begin err++; $display("FAIL gapend_last_gap got %b want 0", o_LED); end
      end
      if (i == 8) begin
        vec++; if (o_LED !== 1'b1) begin err++; $display("FAIL gapend_led got %b want 1", o_LED); end
      end
      if (i == 14) begin
        vec++; if (busy_low !== 0) begin err++; $display("FAIL gapend_no_idle low_cycles=%0d want 0", busy_low); end
      end
    end
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL gapend_pending got busy %b want 0", o_Busy); end
    vec++; if (rises !== 2) begin err++; $display("FAIL gapend_blinks got %0d want 2", rises); end
  endtask

  task automatic test_mid_reset();
    clear_stats();
    // after edge k+7 the second blink is ON with two events still queued
    for (int i = 1; i <= 8; i++) step((i % 2 == 1));
    vec++; if (o_LED !== 1'b1) begin err++; $display("FAIL midrst_setup_led got %b want 1", o_LED); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (o_LED !== 1'b0) begin err++; $display("FAIL midrst_led got %b want 0", o_LED); end
    vec++; if (o_Busy !== 1'b0) begin err++; $display("FAIL midrst_busy got %b want 0", o_Busy); end
    i_Event = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 20; i++) step(1'b0);
    vec++; if (rises !== 0) begin err++; $display("FAIL midrst_blinks got %0d want 0", rises); end
    vec++; if (busy_low !== 20) begin err++; $display("FAIL midrst_busy_after low_cycles=%0d want 20", busy_low); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_queueing();
    test_overflow();
    test_gap_edge();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
